// File: rtl/cnt_ctrl_pkg.sv
// Shared definitions for the counter sequencing controller: state encoding,
// command opcodes and the full-range terminal helper.
package cnt_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_HOLD = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_STOP  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_LOAD  = 2'b11;

    // All-ones value of a w-bit counter, i.e. the largest reachable count.
    function automatic logic [31:0] full_term(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/cnt_core.sv
// Counter datapath: WIDTH-bit register with clear, enable and wrap controls
// plus a combinational compare against the terminal value.
module cnt_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             wrap,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] cnt,
    output logic             eq_term
);

    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_r;

    // Count register: clear dominates, otherwise increment or wrap to zero when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {WIDTH{1'b0}};
        end else if (clr) begin
            cnt_r <= {WIDTH{1'b0}};
        end else if (en) begin
            if (wrap) begin
                cnt_r <= {WIDTH{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt     = cnt_r;
    assign eq_term = (cnt_r == term);

endmodule

// File: rtl/cnt_seq_ctrl.sv
// Sequencing controller: command decode, run/hold/done FSM, terminal
// detection, done pulse and saturating wrap counter around cnt_core.
module cnt_seq_ctrl
    import cnt_ctrl_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [WIDTH-1:0]  cmd_data,
    input  logic              cfg_periodic,
    input  logic              tick_en,
    output logic [WIDTH-1:0]  o_cnt,
    output logic              o_busy,
    output logic              o_done,
    output logic [WRAP_W-1:0] o_wrap_cnt
);

    localparam logic [WIDTH-1:0]  TERM_FULL = WIDTH'(full_term(WIDTH));
    localparam logic [WRAP_W-1:0] WRAP_MAX  = {WRAP_W{1'b1}};
    localparam logic [WRAP_W-1:0] WRAP_ONE  = {{(WRAP_W-1){1'b0}}, 1'b1};

    state_t             state_r;
    state_t             nxt_state_s;
    logic [WIDTH-1:0]   term_r;
    logic               busy_r;
    logic               done_r;
    logic               ready_r;
    logic [WRAP_W-1:0]  wrap_r;

    logic               acc_s;
    logic               start_s;
    logic               stop_s;
    logic               clear_s;
    logic               load_s;
    logic               run_tick_s;
    logic               term_hit_s;
    logic               core_clr_s;
    logic               core_en_s;
    logic               eq_term_s;

    // A command is taken only when the port is ready; STOP/CLEAR/LOAD swallow a same-cycle tick.
    assign acc_s      = cmd_valid && ready_r;
    assign start_s    = acc_s && (cmd_op == OP_START);
    assign stop_s     = acc_s && (cmd_op == OP_STOP);
    assign clear_s    = acc_s && (cmd_op == OP_CLEAR);
    assign load_s     = acc_s && (cmd_op == OP_LOAD);
    assign run_tick_s = (state_r == ST_RUN) && tick_en && !(stop_s || clear_s || load_s);
    assign term_hit_s = run_tick_s && eq_term_s;

    // In one-shot mode the terminal tick must not move the count, so enable only on wrap or below term.
    assign core_clr_s = clear_s || load_s || (start_s && (state_r == ST_DONE));
    assign core_en_s  = run_tick_s && (!eq_term_s || cfg_periodic);

    cnt_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (core_clr_s),
        .en      (core_en_s),
        .wrap    (eq_term_s),
        .term    (term_r),
        .cnt     (o_cnt),
        .eq_term (eq_term_s)
    );

    // Next-state decode; commands outrank ticks, LOAD always lasts a single cycle.
    always_comb begin
        nxt_state_s = state_r;
        case (state_r)
            ST_LOAD: begin
                nxt_state_s = ST_IDLE;
            end
            ST_IDLE, ST_HOLD, ST_DONE: begin
                if (clear_s) begin
                    nxt_state_s = ST_IDLE;
                end else if (load_s) begin
                    nxt_state_s = ST_LOAD;
                end else if (start_s) begin
                    nxt_state_s = ST_RUN;
                end else begin
                    nxt_state_s = state_r;
                end
            end
            ST_RUN: begin
                if (clear_s) begin
                    nxt_state_s = ST_IDLE;
                end else if (load_s) begin
                    nxt_state_s = ST_LOAD;
                end else if (stop_s) begin
                    nxt_state_s = ST_HOLD;
                end else if (term_hit_s && !cfg_periodic) begin
                    nxt_state_s = ST_DONE;
                end else begin
                    nxt_state_s = ST_RUN;
                end
            end
            default: begin
                nxt_state_s = ST_IDLE;
            end
        endcase
    end

    // State, registered status outputs, terminal value and saturating wrap count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            term_r  <= TERM_FULL;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            ready_r <= 1'b1;
            wrap_r  <= {WRAP_W{1'b0}};
        end else begin
            state_r <= nxt_state_s;
            busy_r  <= (nxt_state_s == ST_RUN);
            ready_r <= (nxt_state_s != ST_LOAD);
            done_r  <= term_hit_s;
            if (load_s) begin
                term_r <= (cmd_data == {WIDTH{1'b0}}) ? TERM_FULL : cmd_data;
            end else begin
                term_r <= term_r;
            end
            if (clear_s) begin
                wrap_r <= {WRAP_W{1'b0}};
            end else if (term_hit_s && cfg_periodic && (wrap_r != WRAP_MAX)) begin
                wrap_r <= wrap_r + WRAP_ONE;
            end else begin
                wrap_r <= wrap_r;
            end
        end
    end

    assign cmd_ready  = ready_r;
    assign o_busy     = busy_r;
    assign o_done     = done_r;
    assign o_wrap_cnt = wrap_r;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Self-checking bench for cnt_seq_ctrl (WIDTH=4, WRAP_W=8): directed scenarios
// pinned with literal expectations, then randomized traffic, all compared each
// cycle against a behavioural model of the controller.
module tb_cnt_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic       cfg_periodic;
    logic       tick_en;
    logic [3:0] o_cnt;
    logic       o_busy;
    logic       o_done;
    logic [7:0] o_wrap_cnt;

    int total = 0;
    int bad   = 0;

    // Behavioural model state (bench's own mode numbering)
    localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_HOLD = 3, M_DONE = 4;
    int m_mode, m_cnt, m_term, m_wrap;
    bit m_done;

    cnt_seq_ctrl #(.WIDTH(4), .WRAP_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .cfg_periodic (cfg_periodic),
        .tick_en      (tick_en),
        .o_cnt        (o_cnt),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_wrap_cnt   (o_wrap_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_cnt = 0; m_term = 15; m_wrap = 0; m_done = 0;
    endtask

    // One tick while running: count up, or handle the terminal value by mode.
    task automatic model_tick(input bit per);
        if (m_cnt == m_term) begin
            m_done = 1;
            if (per) begin
                m_cnt  = 0;
                m_wrap = (m_wrap < 255) ? m_wrap + 1 : 255;
            end else begin
                m_mode = M_DONE;
            end
        end else begin
            m_cnt = (m_cnt + 1) % 16;
        end
    endtask

    task automatic model_edge(input bit v, input int op, input int d, input bit t, input bit per);
        bit acc;
        acc    = v && (m_mode != M_LOAD);
        m_done = 0;
        if (m_mode == M_LOAD) begin
            m_mode = M_IDLE;
        end else if (acc && op == 2) begin
            m_mode = M_IDLE; m_cnt = 0; m_wrap = 0;
        end else if (acc && op == 3) begin
            m_term = (d == 0) ? 15 : d; m_cnt = 0; m_mode = M_LOAD;
        end else if (acc && op == 1) begin
            if (m_mode == M_RUN) m_mode = M_HOLD;
        end else if (acc && op == 0 && m_mode != M_RUN) begin
            if (m_mode == M_DONE) m_cnt = 0;
            m_mode = M_RUN;
        end else if (m_mode == M_RUN && t) begin
            model_tick(per);
        end
    endtask

    task automatic compare_all();
        check("cnt",   int'(o_cnt),      m_cnt);
        check("busy",  int'(o_busy),     int'(m_mode == M_RUN));
        check("done",  int'(o_done),     int'(m_done));
        check("ready", int'(cmd_ready),  int'(m_mode != M_LOAD));
        check("wrap",  int'(o_wrap_cnt), m_wrap);
    endtask

    task automatic step(input bit v, input int op, input int d, input bit t);
        cmd_valid = v;
        cmd_op    = 2'(op);
        cmd_data  = 4'(d);
        tick_en   = t;
        @(posedge clk);
        model_edge(v, op, d, t, cfg_periodic);
        #1;
        compare_all();
    endtask

    task automatic cmd(input int op, input int d);
        step(1'b1, op, d, 1'b0);
    endtask

    task automatic idle(input bit t);
        step(1'b0, 0, 0, t);
    endtask

    int dones;
    int seq_exp [9] = '{1, 2, 0, 1, 2, 0, 1, 2, 0};

    initial begin
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 4'd0;
        cfg_periodic = 1'b0; tick_en = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #12;
        check("reset_cnt", int'(o_cnt), 0);
        check("reset_ready", int'(cmd_ready), 1);
        compare_all();
        rst_n = 1'b1;

        // Reset mid-run, then the default full-range terminal must be back
        cmd(3, 5); idle(1'b0); cmd(0, 0);
        repeat (3) idle(1'b1);
        check("pre_reset_cnt", int'(o_cnt), 3);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_cnt", int'(o_cnt), 0);
        check("async_rst_busy", int'(o_busy), 0);
        model_reset();
        compare_all();
        rst_n = 1'b1;
        cmd(0, 0);
        repeat (15) idle(1'b1);
        check("full_term_cnt", int'(o_cnt), 15);
        idle(1'b1);
        check("full_term_done", int'(o_done), 1);

        // One-shot: 0,1,2,3,3 with tick held high from START on
        cmd(2, 0); cmd(3, 3); idle(1'b0);
        step(1'b1, 0, 0, 1'b1);
        check("os_cnt0", int'(o_cnt), 0);
        dones = 0;
        for (int i = 1; i <= 4; i++) begin
            idle(1'b1);
            check("os_cnt", int'(o_cnt), (i < 3) ? i : 3);
            dones += int'(o_done);
        end
        idle(1'b1);
        dones += int'(o_done);
        check("os_dones", dones, 1);
        check("os_busy", int'(o_busy), 0);

        // Periodic with term 2
        cfg_periodic = 1'b1;
        cmd(2, 0); cmd(3, 2); idle(1'b0); cmd(0, 0);
        dones = 0;
        for (int i = 0; i < 9; i++) begin
            idle(1'b1);
            check("per_seq", int'(o_cnt), seq_exp[i]);
            dones += int'(o_done);
        end
        check("per_dones", dones, 3);
        check("per_wrap", int'(o_wrap_cnt), 3);

        // STOP with a simultaneous tick, then resume
        cfg_periodic = 1'b0;
        cmd(2, 0); cmd(3, 9); idle(1'b0); cmd(0, 0);
        idle(1'b1); idle(1'b1);
        step(1'b1, 1, 0, 1'b1);
        check("stop_cnt", int'(o_cnt), 2);
        check("stop_busy", int'(o_busy), 0);
        idle(1'b1);
        check("hold_cnt", int'(o_cnt), 2);
        cmd(0, 0); idle(1'b1);
        check("resume_cnt", int'(o_cnt), 3);

        // LOAD 0: one-cycle ready drop and full-range count
        cmd(2, 0); cmd(3, 0);
        check("load_ready0", int'(cmd_ready), 0);
        idle(1'b0);
        check("load_ready1", int'(cmd_ready), 1);
        cmd(0, 0);
        repeat (15) idle(1'b1);
        check("load0_cnt", int'(o_cnt), 15);
        idle(1'b1);
        check("load0_done", int'(o_done), 1);

        // CLEAR coincident with the terminal tick
        cmd(2, 0); cmd(3, 2); idle(1'b0); cmd(0, 0);
        idle(1'b1); idle(1'b1);
        step(1'b1, 2, 0, 1'b1);
        check("clr_pri_done", int'(o_done), 0);
        check("clr_pri_cnt", int'(o_cnt), 0);
        check("clr_pri_busy", int'(o_busy), 0);

        // Wrap counter saturation
        cfg_periodic = 1'b1;
        cmd(3, 1); idle(1'b0); cmd(0, 0);
        repeat (257 * 2) idle(1'b1);
        check("wrap_sat", int'(o_wrap_cnt), 255);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int r, op, d;
            if ((i % 200) == 0) cfg_periodic = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, 9);
            op = (r < 4) ? 0 : (r < 7) ? 1 : (r < 8) ? 2 : 3;
            d  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 4) : $urandom_range(0, 15);
            step(1'($urandom_range(0, 9) < 3), op, d, 1'($urandom_range(0, 9) < 7));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
